conv_weight_streamer: RTL and testbench

CONV_WEIGHT_STREAMER -- requirements
Module: conv_weight_streamer

---
 rtl/conv_weight_streamer.sv | 176 +++++++++++++++++
 tb/tb_conv_weight_streamer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_weight_streamer.sv
// conv_weight_streamer: streams one kernel's weights from per-lane ROMs.
// Each beat carries one word per lane. A beat moves only on o_valid && i_ready.
// Build options:
//   CONV_WEIGHT_BIAS_EN - append a per-lane bias beat to every kernel.
//   RTL_SIMULATION      - use the behavioural ROM model in place of the
//                         inferred block ROM.
// ROM image: the word at address a in lane l is {l[7:0], a[23:0]}.

module conv_weight_rom #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int LANE       = 0
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] rom_word(input int a);
    logic [31:0] w;
    w = {8'(LANE), 24'(a)};
    return DATA_WIDTH'(w);
  endfunction

`ifdef RTL_SIMULATION
  // behavioural synchronous read, one cycle from address to data
  always_ff @(posedge clk) q <= rom_word(int'(addr));
`else
  typedef logic [DEPTH-1:0][DATA_WIDTH-1:0] image_t;

  function automatic image_t build_image();
    image_t img;
    for (int a = 0; a < DEPTH; a++) img[a] = rom_word(a);
    return img;
  endfunction

  localparam image_t IMAGE = build_image();

  // registered read of the elaborated image, mapped to block ROM
  always_ff @(posedge clk) q <= IMAGE[addr];
`endif
endmodule

module conv_weight_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int KERNEL_LEN = 9,
  parameter int NUM_KERNEL = 4,
  parameter int LANES      = 2,
  localparam int SEL_W     = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic [SEL_W-1:0]            i_kernel_sel,
  input  logic                        i_ready,
  output logic                        o_valid,
  output logic [LANES*DATA_WIDTH-1:0] o_weight,
  output logic                        o_bias,
  output logic                        o_last,
  output logic                        o_busy,
  output logic                        o_err
);
`ifdef CONV_WEIGHT_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  localparam int STRIDE   = KERNEL_LEN + (BIAS_EN ? 1 : 0);
  localparam int LAST_IDX = STRIDE - 1;
  localparam int CNT_W    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  // The kernel table must fit in the ROM.
  if (NUM_KERNEL * STRIDE > 2**ADDR_WIDTH) begin : g_cfg_err
    $error("conv_weight_streamer: NUM_KERNEL*STRIDE exceeds ROM depth");
  end

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

  state_t                               state;
  logic [ADDR_WIDTH-1:0]                rom_addr;
  logic [ADDR_WIDTH-1:0]                rd_addr;
  logic [CNT_W-1:0]                     beat_cnt;
  logic [CNT_W-1:0]                     cnt_next;
  logic                                 bias_q;
  logic                                 xfer;
  logic                                 sel_ok;
  logic [ADDR_WIDTH-1:0]                base_addr;
  logic [LANES-1:0][DATA_WIDTH-1:0]     lane_q;

  assign xfer      = o_valid && i_ready;
  assign sel_ok    = int'(i_kernel_sel) < NUM_KERNEL;
  assign base_addr = ADDR_WIDTH'(int'(i_kernel_sel) * STRIDE);
  assign cnt_next  = beat_cnt + CNT_W'(1);

  // rom_addr tracks the beat on display. On a transfer the ROM is handed the
  // next address so its data lands with no bubble. The final beat does not
  // advance, so the address never leaves the kernel table.
  assign rd_addr = (xfer && !o_last) ? rom_addr + ADDR_WIDTH'(1) : rom_addr;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    conv_weight_rom #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LANE       (l)
    ) u_rom (
      .clk  (clk),
      .addr (rd_addr),
      .q    (lane_q[l])
    );
  end

  // The ROM register holds still while stalled. Gating it with o_valid
  // forces the data output to zero the moment reset asserts.
  assign o_weight = o_valid ? lane_q : '0;
  assign o_bias   = BIAS_EN ? bias_q : 1'b0;

  // stream control FSM: start/validate, one fetch cycle, handshake beats, done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      beat_cnt <= '0;
      o_valid  <= 1'b0;
      bias_q   <= 1'b0;
      o_last   <= 1'b0;
      o_busy   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (sel_ok) begin
              state    <= FETCH;
              rom_addr <= base_addr;
              beat_cnt <= '0;
              o_busy   <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        FETCH: begin
          state   <= STREAM;
          o_valid <= 1'b1;
          o_last  <= (LAST_IDX == 0);
          bias_q  <= BIAS_EN && (LAST_IDX == 0) && (KERNEL_LEN == 0);
        end
        STREAM: begin
          if (xfer) begin
            if (o_last) begin
              state    <= DONE;
              o_valid  <= 1'b0;
              o_last   <= 1'b0;
              bias_q   <= 1'b0;
              beat_cnt <= '0;
            end else begin
              rom_addr <= rom_addr + ADDR_WIDTH'(1);
              beat_cnt <= cnt_next;
              o_last   <= (cnt_next == CNT_W'(LAST_IDX));
              bias_q   <= BIAS_EN && (cnt_next == CNT_W'(LAST_IDX));
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          o_busy   <= 1'b0;
          rom_addr <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_weight_streamer.sv
// Bench for conv_weight_streamer: random and directed streams are checked
// against a beat model built from the kernel layout and the ROM image.
module tb_conv_weight_streamer;
  localparam int DW = 32;
  localparam int KL = 9;
  localparam int LN = 2;
`ifdef CONV_WEIGHT_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif
  localparam int S = KL + (BIAS ? 1 : 0);

  typedef struct packed {
    logic [LN*DW-1:0] w;
    logic             b;
    logic             l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, ready = 1'b0;
  logic [1:0] sel = '0;
  logic valid, bias, last, busy, err;
  logic [LN*DW-1:0] weight;

  logic start3 = 1'b0, ready3 = 1'b0;
  logic [1:0] sel3 = '0;
  logic valid3, bias3, last3, busy3, err3;
  logic [LN*DW-1:0] weight3;

  int n_cmp = 0;
  int n_err = 0;
  beat_t got[$];
  int xcyc[$];

  always #5 clk = ~clk;

  conv_weight_streamer dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_kernel_sel(sel),
    .i_ready(ready), .o_valid(valid), .o_weight(weight), .o_bias(bias),
    .o_last(last), .o_busy(busy), .o_err(err)
  );

  conv_weight_streamer #(.NUM_KERNEL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(start3), .i_kernel_sel(sel3),
    .i_ready(ready3), .o_valid(valid3), .o_weight(weight3), .o_bias(bias3),
    .o_last(last3), .o_busy(busy3), .o_err(err3)
  );

  // Reference beat i of kernel s: kernel s occupies addresses s*S .. s*S+S-1.
  // The bias beat (when enabled) is the one after the KL weights.
  function automatic beat_t exp_beat(input int s, input int i);
    beat_t e;
    int a;
    a = s * S + i;
    e.w = '0;
    for (int l = 0; l < LN; l++) e.w[l*DW +: DW] = {8'(l), 24'(a)};
    e.b = BIAS && (i == KL);
    e.l = (i == S - 1);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a stream on dut and collects the transferred beats. mode 0 keeps
  // ready high, mode 1 uses ready 1,0,0 repeating, mode 2 uses random ready.
  // When the stream reaches beat inj, the task pulses a second start.
  task automatic run_stream(input int s, input int mode, input int inj,
                            output int lat, output int dlat,
                            output int stall_bad, output bit tmo);
    beat_t prev;
    bit prev_stall;
    int last_c;
    got.delete();
    xcyc.delete();
    lat = -1; dlat = -1; stall_bad = 0; tmo = 1'b1;
    prev_stall = 1'b0; last_c = -1; prev = '0;
    start = 1'b1; sel = 2'(s); ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) begin
        start = 1'b0;
        if (prev_stall && (valid !== 1'b1 || {weight, bias, last} !== prev))
          stall_bad++;
        if (valid === 1'b1 && lat < 0) lat = c;
        if (last_c >= 0 && busy === 1'b0) begin
          dlat = c - last_c;
          tmo = 1'b0;
          break;
        end
        if (mode == 0)      ready = 1'b1;
        else if (mode == 1) ready = (c % 3 == 0);
        else                ready = 1'($urandom_range(0, 1));
        if (inj >= 0 && valid === 1'b1 && got.size() == inj) begin
          start = 1'b1;
          sel = 2'(s + 1);
        end
        if (valid === 1'b1 && ready) begin
          got.push_back({weight, bias, last});
          xcyc.push_back(c);
          if (last === 1'b1) last_c = c;
        end
        prev_stall = (valid === 1'b1) && !ready;
        prev = {weight, bias, last};
      end
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({valid, weight, bias, last, busy, err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b w=%h b=%b l=%b busy=%b err=%b, want all 0",
               valid, weight, bias, last, busy, err);
    end
    n_cmp++;
    if ({valid3, weight3, bias3, last3, busy3, err3} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs_nk3: got v=%b busy=%b err=%b, want all 0", valid3, busy3, err3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int lat, dlat, sb;
    bit tmo;
    run_stream(2, 0, -1, lat, dlat, sb, tmo);
    n_cmp++;
    if (tmo) begin n_err++; $display("FAIL nominal_timeout: stream never completed"); end
    n_cmp++;
    if (lat != 2) begin n_err++; $display("FAIL nominal_latency: got %0d, want 2", lat); end
    n_cmp++;
    if (got.size() != S) begin n_err++; $display("FAIL nominal_count: got %0d, want %0d", got.size(), S); end
    for (int i = 0; i < got.size() && i < S; i++) begin
      n_cmp++;
      if (got[i] !== exp_beat(2, i)) begin
        n_err++;
        $display("FAIL nominal_beat%0d: got %h, want %h", i, got[i], exp_beat(2, i));
      end
      n_cmp++;
      if (xcyc[i] != 2 + i) begin
        n_err++;
        $display("FAIL nominal_bubble%0d: got cycle %0d, want %0d", i, xcyc[i], 2 + i);
      end
    end
    n_cmp++;
    if (dlat != 2) begin n_err++; $display("FAIL nominal_busy_fall: got %0d, want 2", dlat); end
  endtask

  task automatic test_backpressure();
    int lat, dlat, sb;
    bit tmo;
    run_stream(1, 1, -1, lat, dlat, sb, tmo);
    n_cmp++;
    if (tmo) begin n_err++; $display("FAIL bp_timeout: stream never completed"); end
    n_cmp++;
    if (lat != 2) begin n_err++; $display("FAIL bp_latency: got %0d, want 2", lat); end
    n_cmp++;
    if (got.size() != S) begin n_err++; $display("FAIL bp_count: got %0d, want %0d", got.size(), S); end
    n_cmp++;
    if (sb != 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable stall cycles, want 0", sb); end
    for (int i = 0; i < got.size() && i < S; i++) begin
      n_cmp++;
      if (got[i] !== exp_beat(1, i)) begin
        n_err++;
        $display("FAIL bp_beat%0d: got %h, want %h", i, got[i], exp_beat(1, i));
      end
    end
  endtask

  task automatic test_random();
    int lat, dlat, sb, s;
    bit tmo;
    for (int r = 0; r < 6; r++) begin
      s = int'($urandom_range(0, 3));
      run_stream(s, 2, -1, lat, dlat, sb, tmo);
      n_cmp++;
      if (tmo || got.size() != S) begin
        n_err++;
        $display("FAIL rand%0d_count: got %0d beats tmo=%b, want %0d", r, got.size(), tmo, S);
      end
      n_cmp++;
      if (sb != 0) begin n_err++; $display("FAIL rand%0d_hold: got %0d, want 0", r, sb); end
      for (int i = 0; i < got.size() && i < S; i++) begin
        n_cmp++;
        if (got[i] !== exp_beat(s, i)) begin
          n_err++;
          $display("FAIL rand%0d_beat%0d: got %h, want %h", r, i, got[i], exp_beat(s, i));
        end
      end
    end
  endtask

  task automatic test_illegal();
    int lat, dlat, sb;
    bit tmo;
    // sel 3 is the top legal kernel on the default build
    run_stream(3, 0, -1, lat, dlat, sb, tmo);
    n_cmp++;
    if (got.size() != S || got[0] !== exp_beat(3, 0) || got[S-1] !== exp_beat(3, S - 1)) begin
      n_err++;
      $display("FAIL sel3_legal: got %0d beats first %h, want %0d first %h",
               got.size(), got.size() > 0 ? got[0] : '0, S, exp_beat(3, 0));
    end
    // with three kernels, sel 3 is out of range
    sel3 = 2'd3; start3 = 1'b1; ready3 = 1'b1;
    step();
    start3 = 1'b0;
    n_cmp++;
    if (err3 !== 1'b1 || valid3 !== 1'b0 || busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL err_pulse: got err=%b v=%b busy=%b, want 1 0 0", err3, valid3, busy3);
    end
    step();
    n_cmp++;
    if (err3 !== 1'b0) begin n_err++; $display("FAIL err_width: got %b, want 0", err3); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (valid3 !== 1'b0 || busy3 !== 1'b0) begin
        n_err++;
        $display("FAIL err_idle%0d: got v=%b busy=%b, want 0 0", c, valid3, busy3);
      end
      step();
    end
    // a legal start still works afterwards
    sel3 = 2'd2; start3 = 1'b1;
    step();
    start3 = 1'b0;
    n_cmp++;
    if (busy3 !== 1'b1) begin n_err++; $display("FAIL nk3_busy: got %b, want 1", busy3); end
    step();
    n_cmp++;
    if (valid3 !== 1'b1 || weight3[DW +: DW] !== {8'd1, 24'(2 * S)}) begin
      n_err++;
      $display("FAIL nk3_first: got v=%b w1=%h, want 1 %h", valid3, weight3[DW +: DW], {8'd1, 24'(2 * S)});
    end
    for (int c = 0; c < 40 && busy3 === 1'b1; c++) step();
    n_cmp++;
    if (busy3 !== 1'b0) begin n_err++; $display("FAIL nk3_done: got busy %b, want 0", busy3); end
  endtask

  task automatic test_start_busy();
    int lat, dlat, sb;
    bit tmo;
    run_stream(0, 0, 4, lat, dlat, sb, tmo);
    n_cmp++;
    if (tmo || got.size() != S || dlat != 2) begin
      n_err++;
      $display("FAIL busy_count: got %0d beats dlat=%0d, want %0d dlat=2", got.size(), dlat, S);
    end
    for (int i = 0; i < got.size() && i < S; i++) begin
      n_cmp++;
      if (got[i] !== exp_beat(0, i)) begin
        n_err++;
        $display("FAIL busy_beat%0d: got %h, want %h", i, got[i], exp_beat(0, i));
      end
    end
    n_cmp++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_no_queue: got v=%b busy=%b, want 0 0", valid, busy);
    end
    run_stream(3, 0, -1, lat, dlat, sb, tmo);
    n_cmp++;
    if (tmo || got.size() != S || lat != 2) begin
      n_err++;
      $display("FAIL busy_next: got %0d beats lat=%0d, want %0d lat=2", got.size(), lat, S);
    end
    for (int i = 0; i < got.size() && i < S; i++) begin
      n_cmp++;
      if (got[i] !== exp_beat(3, i)) begin
        n_err++;
        $display("FAIL busy_next_beat%0d: got %h, want %h", i, got[i], exp_beat(3, i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, lat, dlat, sb;
    bit tmo;
    n = 0;
    start = 1'b1; sel = 2'd1; ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      if (valid === 1'b1 && ready) n++;
      step();
    end
    ready = 1'b0;
    step(); step();
    n_cmp++;
    if (valid !== 1'b1 || {weight, bias, last} !== exp_beat(1, 5)) begin
      n_err++;
      $display("FAIL rmid_stall: got v=%b %h, want 1 %h", valid, {weight, bias, last}, exp_beat(1, 5));
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid, weight, bias, last, busy, err} !== '0) begin
      n_err++;
      $display("FAIL rmid_async: got v=%b w=%h b=%b l=%b busy=%b, want all 0",
               valid, weight, bias, last, busy);
    end
    step();
    n_cmp++;
    if ({valid, busy} !== 2'b00) begin n_err++; $display("FAIL rmid_held: got v=%b busy=%b, want 0 0", valid, busy); end
    rst_n = 1'b1;
    run_stream(0, 0, -1, lat, dlat, sb, tmo);
    n_cmp++;
    if (tmo || got.size() != S || lat != 2) begin
      n_err++;
      $display("FAIL rmid_restart: got %0d beats lat=%0d, want %0d lat=2", got.size(), lat, S);
    end
    for (int i = 0; i < got.size() && i < S; i++) begin
      n_cmp++;
      if (got[i] !== exp_beat(0, i)) begin
        n_err++;
        $display("FAIL rmid_beat%0d: got %h, want %h", i, got[i], exp_beat(0, i));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_random();
    test_illegal();
    test_start_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
